// File: rtl/ext_count_gate_ctrl_pkg.sv
// Shared types and default constants for the external edge-counter gate sequencer.
package ext_count_pkg;

  localparam int unsigned GATE_CYCLES_DEF = 50_000_000;
  localparam int unsigned CNT_WIDTH_DEF   = 16;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned TMR_W_DEF       = $clog2(GATE_CYCLES_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    GATE  = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Gate timer width; the timer only ever holds GATE_CYCLES-1 down to 0.
  function automatic int unsigned tmr_width(input int unsigned gate_cycles);
    return (gate_cycles < 2) ? 1 : $clog2(gate_cycles);
  endfunction

endpackage

// File: rtl/ext_count_gate_ctrl_if.sv
// Control/status bundle between a measurement host and the gate sequencer.
interface ext_count_gate_ctrl_if
  import ext_count_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) ();

  logic                 start_i;
  logic                 cont_i;
  logic                 abort_i;
  logic [CNT_WIDTH-1:0] result_o;
  logic                 valid_o;
  logic                 ovf_o;
  logic                 busy_o;

  modport master (
    output start_i, cont_i, abort_i,
    input  result_o, valid_o, ovf_o, busy_o
  );

  modport slave (
    input  start_i, cont_i, abort_i,
    output result_o, valid_o, ovf_o, busy_o
  );

endinterface

// File: rtl/ext_count_gate_ctrl_edge_sync_detect.sv
// Synchronises an asynchronous pin and emits a one-cycle pulse per rising edge.
module edge_sync_detect
  import ext_count_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Decoded from registered values only, so it is glitch-free within the cycle.
  assign rise_c = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ext_count_gate_ctrl.sv
// Gate-time sequencer: counts pin rising edges over a programmable window and latches the result.
module ext_count_gate_ctrl
  import ext_count_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_WIDTH   = CNT_WIDTH_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  CLK_IN,
  input  logic                  RST_N,
  input  logic                  D16_i,
  ext_count_gate_ctrl_if.slave  bus,
  output logic                  LED_D9,
  output logic                  LED_D8,
  output logic                  LED_D7,
  output logic                  LED_D6,
  output logic                  LED_D5,
  output logic                  LED_D4,
  output logic                  LED_D3,
  output logic                  LED_D2
);

  localparam int unsigned       TMR_W    = tmr_width(GATE_CYCLES);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(GATE_CYCLES - 1);

  state_t               state_q, state_d;
  logic                 pin_edge_c;
  logic                 arm_c, count_c, latch_c;
  logic [TMR_W-1:0]     timer_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 sat_q;
  logic [CNT_WIDTH-1:0] result_q;
  logic                 ovf_q;
  logic                 valid_q;
  logic                 busy_q;

  edge_sync_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (CLK_IN),
    .rst_n  (RST_N),
    .din    (D16_i),
    .rise_c (pin_edge_c)
  );

  always_ff @(posedge CLK_IN) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus datapath strobes; abort beats both start and the latch update.
  always_comb begin
    state_d = state_q;
    arm_c   = 1'b0;
    count_c = 1'b0;
    latch_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.abort_i) state_d = ARM;
      end
      ARM: begin
        arm_c   = 1'b1;
        state_d = bus.abort_i ? IDLE : GATE;
      end
      GATE: begin
        count_c = 1'b1;
        if (bus.abort_i)           state_d = IDLE;
        else if (timer_q == '0)    state_d = LATCH;
      end
      LATCH: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          latch_c = 1'b1;
          state_d = bus.cont_i ? ARM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gate timer, saturating edge counter and result/status registers.
  always_ff @(posedge CLK_IN) begin
    if (!RST_N) begin
      timer_q  <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= (state_d == LATCH);
      busy_q  <= (state_d != IDLE);

      if (arm_c)                         timer_q <= TMR_LOAD;
      else if (count_c && timer_q != '0) timer_q <= timer_q - TMR_W'(1);

      if (arm_c) begin
        cnt_q <= '0;
        sat_q <= 1'b0;
      end else if (count_c && pin_edge_c) begin
        if (&cnt_q) sat_q <= 1'b1;
        else        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end

      if (latch_c) begin
        result_q <= cnt_q;
        ovf_q    <= sat_q;
      end
    end
  end

  assign bus.result_o = result_q;
  assign bus.valid_o  = valid_q;
  assign bus.ovf_o    = ovf_q;
  assign bus.busy_o   = busy_q;

  assign {LED_D9, LED_D8, LED_D7, LED_D6, LED_D5, LED_D4, LED_D3, LED_D2} =
    result_q[CNT_WIDTH-1 -: 8];

endmodule

// File: tb/tb_ext_count_gate_ctrl.sv
// Directed bench for ext_count_gate_ctrl: a 16-cycle gate unit and a 1024-cycle gate unit for saturation.
module tb_ext_count_gate_ctrl;

  logic       clk;
  logic       rst_n;
  logic       d_a;
  logic       d_b;
  logic [7:0] leds_a;
  logic [7:0] leds_b;

  int cyc;
  int vectors;
  int miscompares;
  int per_a, ph_a, per_b, ph_b;
  int pul_a [4];

  ext_count_gate_ctrl_if #(.CNT_WIDTH(8)) ifa ();
  ext_count_gate_ctrl_if #(.CNT_WIDTH(8)) ifb ();

  ext_count_gate_ctrl #(
    .GATE_CYCLES (16),
    .CNT_WIDTH   (8),
    .SYNC_STAGES (2)
  ) u_a (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .D16_i  (d_a),
    .bus    (ifa),
    .LED_D9 (leds_a[7]),
    .LED_D8 (leds_a[6]),
    .LED_D7 (leds_a[5]),
    .LED_D6 (leds_a[4]),
    .LED_D5 (leds_a[3]),
    .LED_D4 (leds_a[2]),
    .LED_D3 (leds_a[1]),
    .LED_D2 (leds_a[0])
  );

  ext_count_gate_ctrl #(
    .GATE_CYCLES (1024),
    .CNT_WIDTH   (8),
    .SYNC_STAGES (2)
  ) u_b (
    .CLK_IN (clk),
    .RST_N  (rst_n),
    .D16_i  (d_b),
    .bus    (ifb),
    .LED_D9 (leds_b[7]),
    .LED_D8 (leds_b[6]),
    .LED_D7 (leds_b[5]),
    .LED_D6 (leds_b[4]),
    .LED_D5 (leds_b[3]),
    .LED_D4 (leds_b[2]),
    .LED_D3 (leds_b[1]),
    .LED_D2 (leds_b[0])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic wave(input int c, input int per, input int ph);
    return (per != 0) && (c >= ph) && (((c - ph) % per) < (per / 2));
  endfunction

  task automatic set_pins();
    d_a = wave(cyc, per_a, ph_a);
    for (int i = 0; i < 4; i++) if (pul_a[i] == cyc) d_a = 1'b1;
    d_b = wave(cyc, per_b, ph_b);
  endtask

  // One clock: inputs for the new cycle are applied and outputs settle 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    set_pins();
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Square wave aligned so its first rise is driven in the start cycle s; returns in cycle s+1.
  task automatic begin_a(input int per, output int s);
    ph_a  = cyc + 1;
    per_a = per;
    step();
    s = cyc;
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
  endtask

  task automatic begin_b(input int per, output int s);
    ph_b  = cyc + 1;
    per_b = per;
    step();
    s = cyc;
    ifb.start_i = 1'b1;
    step();
    ifb.start_i = 1'b0;
  endtask

  // Two one-cycle pin pulses at offsets from the start cycle; edge lands two cycles after each.
  task automatic begin_pulses(input int p0, input int p1, output int s);
    s = cyc + 3;
    pul_a[0] = s + p0;
    pul_a[1] = s + p1;
    run_to(s);
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
  endtask

  task automatic check_zero_a(input string tag);
    check({tag, "_result"}, 32'(ifa.result_o), 32'd0);
    check({tag, "_ovf"},    32'(ifa.ovf_o),    32'd0);
    check({tag, "_valid"},  32'(ifa.valid_o),  32'd0);
    check({tag, "_busy"},   32'(ifa.busy_o),   32'd0);
    check({tag, "_leds"},   32'(leds_a),       32'd0);
  endtask

  task automatic expect_latch_a(input int s, input string tag, input int cnt);
    run_to(s + 17);
    check({tag, "_valid_early"}, 32'(ifa.valid_o), 32'd0);
    run_to(s + 18);
    check({tag, "_valid"},       32'(ifa.valid_o), 32'd1);
    run_to(s + 19);
    check({tag, "_result"},      32'(ifa.result_o), 32'(cnt));
    check({tag, "_busy_done"},   32'(ifa.busy_o),   32'd0);
  endtask

  initial begin
    int s;
    vectors = 0;
    miscompares = 0;
    cyc = 0;
    per_a = 0; ph_a = 0; per_b = 0; ph_b = 0;
    for (int i = 0; i < 4; i++) pul_a[i] = -100;
    rst_n = 1'b0;
    d_a = 1'b0;
    d_b = 1'b0;
    ifa.start_i = 1'b0; ifa.cont_i = 1'b0; ifa.abort_i = 1'b0;
    ifb.start_i = 1'b0; ifb.cont_i = 1'b0; ifb.abort_i = 1'b0;

    idle(3);
    check_zero_a("rst");
    check("rst_b_result", 32'(ifb.result_o), 32'd0);
    check("rst_b_busy",   32'(ifb.busy_o),   32'd0);
    rst_n = 1'b1;
    idle(4);

    // Basic period-4 count: four GATE edges, the fifth rise lands in LATCH.
    begin_a(4, s);
    check("basic_arm_busy", 32'(ifa.busy_o), 32'd1);
    run_to(s + 17);
    check("basic_valid_early", 32'(ifa.valid_o), 32'd0);
    run_to(s + 18);
    check("basic_valid", 32'(ifa.valid_o), 32'd1);
    check("basic_busy_latch", 32'(ifa.busy_o), 32'd1);
    run_to(s + 19);
    check("basic_valid_once", 32'(ifa.valid_o), 32'd0);
    check("basic_busy_done",  32'(ifa.busy_o),  32'd0);
    check("basic_result",     32'(ifa.result_o), 32'd4);
    check("basic_ovf",        32'(ifa.ovf_o),    32'd0);
    check("basic_leds",       32'(leds_a),       32'd4);
    per_a = 0;
    idle(4);

    // Continuous mode, period-8 input: a result of 2 every 18 cycles.
    ifa.cont_i = 1'b1;
    begin_a(8, s);
    run_to(s + 18);
    check("cont_valid1", 32'(ifa.valid_o), 32'd1);
    run_to(s + 19);
    check("cont_result1", 32'(ifa.result_o), 32'd2);
    check("cont_busy1",   32'(ifa.busy_o),   32'd1);
    run_to(s + 35);
    check("cont_valid_gap", 32'(ifa.valid_o), 32'd0);
    run_to(s + 36);
    check("cont_valid2", 32'(ifa.valid_o), 32'd1);
    run_to(s + 37);
    check("cont_result2", 32'(ifa.result_o), 32'd2);
    run_to(s + 40);
    ifa.cont_i = 1'b0;
    run_to(s + 54);
    check("cont_valid3", 32'(ifa.valid_o), 32'd1);
    run_to(s + 55);
    check("cont_result3", 32'(ifa.result_o), 32'd2);
    check("cont_stop_busy", 32'(ifa.busy_o), 32'd0);
    per_a = 0;
    idle(4);

    // Abort mid-gate: no valid and the previous result survives.
    begin_a(4, s);
    run_to(s + 8);
    ifa.abort_i = 1'b1;
    step();
    ifa.abort_i = 1'b0;
    check("abort_busy", 32'(ifa.busy_o), 32'd0);
    run_to(s + 18);
    check("abort_no_valid", 32'(ifa.valid_o), 32'd0);
    run_to(s + 20);
    check("abort_result_held", 32'(ifa.result_o), 32'd2);
    per_a = 0;
    idle(4);

    // A start during GATE must not restart the window.
    begin_a(4, s);
    run_to(s + 10);
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    expect_latch_a(s, "restart", 4);
    per_a = 0;
    idle(4);

    // Abort and start together in IDLE: abort wins.
    ifa.start_i = 1'b1;
    ifa.abort_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    ifa.abort_i = 1'b0;
    check("conflict_busy1", 32'(ifa.busy_o), 32'd0);
    step();
    check("conflict_busy2", 32'(ifa.busy_o), 32'd0);
    check("conflict_valid", 32'(ifa.valid_o), 32'd0);
    idle(2);

    // Boundary edges: ARM + last GATE, first + last GATE, first GATE + LATCH.
    begin_pulses(-1, 15, s);
    expect_latch_a(s, "bnd_arm_last", 1);
    idle(4);
    begin_pulses(0, 15, s);
    expect_latch_a(s, "bnd_first_last", 2);
    idle(4);
    begin_pulses(0, 16, s);
    expect_latch_a(s, "bnd_first_latch", 1);
    for (int i = 0; i < 4; i++) pul_a[i] = -100;
    idle(4);

    // Saturation: 256 rises into an 8-bit counter, then an empty window clears the flag.
    begin_b(4, s);
    run_to(s + 500);
    check("sat_busy_mid", 32'(ifb.busy_o), 32'd1);
    run_to(s + 1026);
    check("sat_valid", 32'(ifb.valid_o), 32'd1);
    run_to(s + 1027);
    check("sat_result", 32'(ifb.result_o), 32'd255);
    check("sat_ovf",    32'(ifb.ovf_o),    32'd1);
    check("sat_leds",   32'(leds_b),       32'd255);
    per_b = 0;
    idle(4);
    begin_b(0, s);
    run_to(s + 1026);
    check("sat_clear_valid", 32'(ifb.valid_o), 32'd1);
    run_to(s + 1027);
    check("sat_clear_result", 32'(ifb.result_o), 32'd0);
    check("sat_clear_ovf",    32'(ifb.ovf_o),    32'd0);

    // One-cycle reset in the middle of a gate, then a clean measurement.
    begin_a(4, s);
    run_to(s + 8);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_zero_a("midrst");
    per_a = 0;
    idle(4);
    begin_a(4, s);
    expect_latch_a(s, "post_rst", 4);
    check("post_rst_ovf", 32'(ifa.ovf_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
